// File: rtl/scr_sched_pkg.sv
// Shared types, constants and the round-robin search for the TX scrambler scheduler.
package scr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_WAIT_DONE,
    ST_RESEED
  } scr_sched_state_e;

  localparam int SCR_WORD_W      = 32;
  localparam int SCR_TIMEOUT_CYC = 8;

  // First valid index after ptr, wrapping within n requesters (n <= 8).
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input logic [7:0] valid,
                                         input int n);
    logic [2:0] g;
    logic [2:0] idx;
    logic       hit;
    g   = ptr;
    hit = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = 3'((int'(ptr) + i) % n);
      if (i <= n && !hit && valid[idx]) begin
        g   = idx;
        hit = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/scr_tx_sched_rr_arbiter.sv
// Round-robin arbiter: combinational grant from the pointer, pointer moves on advance.
module rr_arbiter
  import scr_sched_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    grant_idx = IW'(rr_next(3'(ptr_q), 8'(valid), NUM_REQ));
    grant     = '0;
    if (|valid) grant[grant_idx] = 1'b1;
    ptr_d = advance ? grant_idx : ptr_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= IW'(NUM_REQ - 1);
    else     ptr_q <= ptr_d;

endmodule

// File: rtl/scr_tx_sched.sv
// Bit-serial TX scheduler feeding the scrambler; periodic LFSR reseed.
// Optional WAIT_DONE watchdog with sticky err: define SCR_SCHED_TIMEOUT_EN.
module scr_tx_sched
  import scr_sched_pkg::*;
#(
  parameter  int WORD_W       = SCR_WORD_W,
  parameter  int NUM_REQ      = 2,
  parameter  int RESEED_WORDS = 16,
  localparam int SW           = $clog2(NUM_REQ),
  localparam int BW           = $clog2(WORD_W),
  localparam int CW           = (RESEED_WORDS > 0) ? $clog2(RESEED_WORDS + 1) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      scr_rst_n,
  output logic                      scr_start,
  output logic                      scr_in,
  input  logic                      scr_out,
  input  logic                      scr_done,
  output logic                      ser_valid,
  output logic                      ser_data,
  output logic                      ser_last,
  output logic [SW-1:0]             ser_src,
  output logic                      busy,
  output logic                      err
);

  scr_sched_state_e state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [SW-1:0]     src_q, src_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     wc_q, wc_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_last_q, ser_last_d;
  logic              rst_hold_q;
  logic [NUM_REQ-1:0] gnt;
  logic [SW-1:0]     gnt_idx;
  logic              adv;
`ifdef SCR_SCHED_TIMEOUT_EN
  logic [3:0]        wd_q, wd_d;
  logic              err_q, err_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk), .rst(rst), .valid(req_valid), .advance(adv),
    .grant(gnt), .grant_idx(gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    src_d   = src_q;
    bit_d   = bit_q;
    wc_d    = wc_q;
    adv     = 1'b0;
`ifdef SCR_SCHED_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: if (|req_valid) begin
        adv     = 1'b1;
        word_d  = req_data[int'(gnt_idx)*WORD_W +: WORD_W];
        src_d   = gnt_idx;
        state_d = ST_START;
      end
      ST_START: begin
        bit_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_q == BW'(WORD_W - 1)) begin
          bit_d   = '0;
          state_d = ST_WAIT_DONE;
`ifdef SCR_SCHED_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (scr_done) begin
          if (RESEED_WORDS != 0 && int'(wc_q) + 1 >= RESEED_WORDS) begin
            wc_d    = '0;
            state_d = ST_RESEED;
          end else begin
            wc_d    = (RESEED_WORDS == 0) ? wc_q : wc_q + 1'b1;
            state_d = ST_IDLE;
          end
        end
`ifdef SCR_SCHED_TIMEOUT_EN
        // Stuck scrambler: flag it and force a fresh LFSR seed.
        else if (wd_q == 4'(SCR_TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          wc_d    = '0;
          state_d = ST_RESEED;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      ST_RESEED: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Downstream beat is the scrambler output one cycle behind scr_in.
    ser_valid_d = (state_q == ST_SHIFT);
    ser_data_d  = ser_valid_d & scr_out;
    ser_last_d  = ser_valid_d && (bit_q == BW'(WORD_W - 1));
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      src_q       <= '0;
      bit_q       <= '0;
      wc_q        <= '0;
      ser_valid_q <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_last_q  <= 1'b0;
      rst_hold_q  <= 1'b1;
`ifdef SCR_SCHED_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      src_q       <= src_d;
      bit_q       <= bit_d;
      wc_q        <= wc_d;
      ser_valid_q <= ser_valid_d;
      ser_data_q  <= ser_data_d;
      ser_last_q  <= ser_last_d;
      rst_hold_q  <= 1'b0;
`ifdef SCR_SCHED_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end

  // rst_hold_q keeps the scrambler in reset for one cycle after rst releases.
  assign scr_rst_n = ~rst_hold_q & (state_q != ST_RESEED);
  assign req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
  assign scr_start = (state_q == ST_START);
  assign scr_in    = (state_q == ST_SHIFT) & word_q[bit_q];
  assign ser_valid = ser_valid_q;
  assign ser_data  = ser_data_q;
  assign ser_last  = ser_last_q;
  assign ser_src   = src_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef SCR_SCHED_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
